// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver with 2-flop input synchroniser and mid-bit sampling; one-cycle DV or frame-error strobe.
// Latency: 3 + (CLKS_PER_BIT-1)/2 + 9*CLKS_PER_BIT cycles from the start edge to the strobe.
// No backpressure: the byte is strobed once and held, so the consumer must take it on the strobe cycle.
module uart_rx_frame #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Frame_Err,
    output logic       o_Rx_Active
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_CLEANUP
    } state_t;

    state_t        state, state_nxt;
    logic          rx_meta, rx_s;
    logic [CW-1:0] count, count_nxt;
    logic [2:0]    index, index_nxt;
    logic [7:0]    shift, shift_nxt;
    logic [7:0]    byte_nxt;
    logic          dv_nxt, ferr_nxt;

    // Idle-high line, so the synchroniser resets to 1 to avoid a false start.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_Rx_Serial;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state          <= S_IDLE;
            count          <= '0;
            index          <= '0;
            shift          <= '0;
            o_Rx_Byte      <= '0;
            o_Rx_DV        <= 1'b0;
            o_Rx_Frame_Err <= 1'b0;
        end else begin
            state          <= state_nxt;
            count          <= count_nxt;
            index          <= index_nxt;
            shift          <= shift_nxt;
            o_Rx_Byte      <= byte_nxt;
            o_Rx_DV        <= dv_nxt;
            o_Rx_Frame_Err <= ferr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        index_nxt = index;
        shift_nxt = shift;
        byte_nxt  = o_Rx_Byte;
        dv_nxt    = 1'b0;
        ferr_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                count_nxt = '0;
                index_nxt = '0;
                if (!rx_s) state_nxt = S_START;
            end
            S_START: begin
                // Re-check the line half a bit in; a high here was a glitch.
                if (count != HALF) begin
                    count_nxt = count + 1'b1;
                end else begin
                    count_nxt = '0;
                    state_nxt = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (count != LAST) begin
                    count_nxt = count + 1'b1;
                end else begin
                    count_nxt        = '0;
                    shift_nxt[index] = rx_s;
                    if (index == 3'd7) begin
                        index_nxt = '0;
                        state_nxt = S_STOP;
                    end else begin
                        index_nxt = index + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (count != LAST) begin
                    count_nxt = count + 1'b1;
                end else begin
                    count_nxt = '0;
                    state_nxt = S_CLEANUP;
                    if (rx_s) begin
                        byte_nxt = shift;
                        dv_nxt   = 1'b1;
                    end else begin
                        ferr_nxt = 1'b1;
                    end
                end
            end
            S_CLEANUP: begin
                count_nxt = '0;
                state_nxt = S_IDLE;
            end
            default: begin
                count_nxt = '0;
                index_nxt = '0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign o_Rx_Active = (state == S_START) || (state == S_DATA) || (state == S_STOP);

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Serial UART receiver: recovers 8-bit bytes from an asynchronous line framed as 1 start bit, 8 data bits (LSB first), 1 stop bit, no parity. It is the receive-side counterpart of the team's UART transmitter and shares its CLKS_PER_BIT convention, so the two can be paired on one link or looped back for test. It synchronises the raw pin, validates the start bit at mid-bit, samples each bit at its centre, and reports each byte with a one-cycle valid strobe or a framing-error strobe.

## Interface
- CLKS_PER_BIT, default 87: clock cycles per bit = f(i_Clock)/baud. Legal range 4..65535.
- i_Clock  in  1  sole clock; all logic on rising edge.
- i_Reset  in  1  synchronous, active-high reset.
- i_Rx_Serial  in  1  raw asynchronous serial line; idle high.
- o_Rx_DV  out  1  one-cycle pulse: o_Rx_Byte holds a newly received valid byte.
- o_Rx_Byte  out  8  last valid byte; held until the next valid byte.
- o_Rx_Frame_Err  out  1  one-cycle pulse: stop bit sampled low.
- o_Rx_Active  out  1  high while a frame is being received, from START through STOP.

## Operation
- Input passes through a 2-flop synchroniser. Both flops reset to 1. All decisions use the second flop (rx_s).
- Bit counter width is $clog2(CLKS_PER_BIT). H = (CLKS_PER_BIT-1)/2, integer division.
- The 3-bit index selects the data bit. The shift/assembly register is internal and separate from o_Rx_Byte.
- States and transitions:
  - IDLE: count=0, index=0. If rx_s==0, go to START.
  - START: increment count until count==H. At the next edge: if rx_s==0, count=0 and go to DATA. Otherwise go to IDLE (glitch reject, no strobe).
  - DATA: increment count until count==CLKS_PER_BIT-1. At the next edge: count=0, store rx_s into bit[index].
    - If index<7, increment index.
    - Otherwise, index=0 and go to STOP.
  - STOP: increment count until count==CLKS_PER_BIT-1. At the next edge, sample rx_s:
    - If rx_s==1: copy the assembled byte to o_Rx_Byte and pulse o_Rx_DV.
    - If rx_s==0: pulse o_Rx_Frame_Err; o_Rx_Byte is unchanged.
    - Either way, go to CLEANUP.
  - CLEANUP: one cycle; clear strobes; go to IDLE.
  - Unused encodings go to IDLE.
- o_Rx_Active is 1 in START, DATA and STOP, and 0 in IDLE and CLEANUP.
- o_Rx_DV and o_Rx_Frame_Err are mutually exclusive and never high for more than one cycle.
- A line held low after a framing error, e.g. a break, re-enters START from IDLE. Each break of ≥10 bit-times therefore yields repeated Frame_Err pulses, one per 10-bit window plus CLEANUP/IDLE cycles.
- Reset, including mid-frame, takes effect at the next edge:
  - state=IDLE, counters=0, synchroniser=1.
  - o_Rx_DV=0, o_Rx_Frame_Err=0, o_Rx_Active=0, o_Rx_Byte=8'h00.
  - The partial byte is discarded.

## Timing
- Reset values: o_Rx_DV=0, o_Rx_Byte=0, o_Rx_Frame_Err=0, o_Rx_Active=0.
- Let edge e be the first rising edge at which i_Rx_Serial is sampled low for a start bit.
  - rx_s is low after edge e+1.
  - START is entered at edge e+2.
  - Start validation happens at edge e+3+H.
  - Data bit k is sampled at edge e+3+H+(k+1)·CLKS_PER_BIT.
  - Stop is sampled at edge e+3+H+9·CLKS_PER_BIT.
- o_Rx_DV or o_Rx_Frame_Err is high for exactly the cycle after the stop-sample edge. Latency = 3+H+9·CLKS_PER_BIT cycles (829 at the default).
- o_Rx_Active rises the cycle after edge e+2 and falls together with the strobe.
- Back-to-back frames: a start edge arriving during CLEANUP or later is accepted. The minimum gap from the stop-bit centre to the next start edge is 0.5 bit.
- Glitch rejection: a low pulse on rx_s shorter than H+1 cycles produces no strobe and no byte change.

## Test plan
- Single byte, CLKS_PER_BIT=87: drive 0x37 with correct framing. Required: exactly one o_Rx_DV pulse at latency 829 after the start edge, o_Rx_Byte=0x37, no Frame_Err, Active high for the frame.
- Back-to-back 0x00, 0xFF, 0xA5 with zero idle between stop and next start. Required: three DV pulses in order with matching bytes; no Frame_Err.
- Framing error: 0x5A sent after a valid 0x11, with its stop bit driven low. Required: one o_Rx_Frame_Err pulse, no DV, o_Rx_Byte stays 0x11.
- Glitch: 20-cycle low pulse on an idle line. Required: return to IDLE, no strobes, o_Rx_Byte unchanged.
- Reset mid-frame: assert i_Reset for 1 cycle during data bit 4 of 0xC3. Required: all outputs 0 the next cycle and no strobe for that frame. A following 0x3C is received correctly.
- Loopback with the team transmitter at CLKS_PER_BIT=8, all 256 byte values. Required: every received byte equals the sent byte; DV count = 256.
